hpm_counter_bank: RTL

- Parametrised bank of RISC-V machine hardware performance monitor counters: mhpmcounter3..(3+NUM_COUNTERS-1), their high halves, the mhpmevent selectors, and mcountinhibit.
- Replaces the read-as-zero handling of the mhpm address ranges in the CSR file.
- Adds event selection, per-counter inhibit, and Sscofpmf-style sticky overflow with a local counter-overflow interrupt request.
- Sits beside csr on the same address/write bus; the CSR read mux selects read_value whenever read_hit is 1.

---
 rtl/hpm_counter_bank_if.sv | 23 ++
 rtl/hpm_counter_bank.sv | 122 ++++++++++++
 2 files changed

// File: rtl/hpm_counter_bank_if.sv
// CSR-side bus of the HPM counter bank: address/write strobe, combinational read data,
// event strobes in and the local counter-overflow interrupt out.
interface hpm_counter_bank_if #(
    parameter int unsigned NUM_EVENTS = 8
);
    logic [11:0]           address;
    logic                  write_enable;
    logic [31:0]           write_value;
    logic [31:0]           read_value;
    logic                  read_hit;
    logic [NUM_EVENTS-1:0] event_pulses;
    logic                  lcofi;

    modport master (
        output address, write_enable, write_value, event_pulses,
        input  read_value, read_hit, lcofi
    );

    modport slave (
        input  address, write_enable, write_value, event_pulses,
        output read_value, read_hit, lcofi
    );
endinterface

// File: rtl/hpm_counter_bank.sv
// Machine HPM counters 3..3+NUM_COUNTERS-1 with event selects, mcountinhibit,
// sticky overflow (OF in mhpmeventh[31]) and a registered lcofi request.
module hpm_counter_bank #(
    parameter int unsigned NUM_COUNTERS  = 4,
    parameter int unsigned COUNTER_WIDTH = 64,
    parameter int unsigned NUM_EVENTS    = 8
) (
    input  logic              clock,
    input  logic              reset,
    hpm_counter_bank_if.slave bus
);
    localparam int unsigned SELW = $clog2(NUM_EVENTS + 1);
    localparam int unsigned EVW  = 2 ** SELW;

    logic [COUNTER_WIDTH-1:0] r_cnt [NUM_COUNTERS];
    logic [SELW-1:0]          r_sel [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  r_of;
    logic [NUM_COUNTERS-1:0]  r_inh;
    logic                     r_lcofi;

    logic [COUNTER_WIDTH-1:0] w_cnt_nxt [NUM_COUNTERS];
    logic [SELW-1:0]          w_sel_nxt [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  w_of_nxt;
    logic [NUM_COUNTERS-1:0]  w_inh_nxt;
    logic [EVW-1:0]           w_ev_pad;

    logic [6:0] w_grp;
    logic [4:0] w_idx;
    logic [4:0] w_ci;
    logic       w_idx_ok;
    logic       w_is_lo, w_is_hi, w_is_ev, w_is_evh, w_is_inh;
    logic [31:0] w_rdata;

    assign w_grp    = bus.address[11:5];
    assign w_idx    = bus.address[4:0];
    assign w_ci     = w_idx - 5'd3;
    assign w_idx_ok = (w_idx >= 5'd3);
    assign w_is_lo  = (w_grp == 7'h58) && w_idx_ok;
    assign w_is_hi  = (w_grp == 7'h5C) && w_idx_ok;
    assign w_is_ev  = (w_grp == 7'h19) && w_idx_ok;
    assign w_is_evh = (w_grp == 7'h39) && w_idx_ok;
    assign w_is_inh = (bus.address == 12'h320);

    assign bus.read_hit   = w_is_lo | w_is_hi | w_is_ev | w_is_evh | w_is_inh;
    assign bus.read_value = w_rdata;
    assign bus.lcofi      = r_lcofi;

    always_comb begin
        w_rdata = '0;
        if (w_is_inh) begin
            w_rdata[3 +: NUM_COUNTERS] = r_inh;
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (w_ci == 5'(i)) begin
                if (w_is_lo)  w_rdata = r_cnt[i][31:0];
                if (w_is_hi)  w_rdata = 32'(r_cnt[i] >> 32);
                if (w_is_ev)  w_rdata = 32'(r_sel[i]);
                if (w_is_evh) w_rdata = {r_of[i], 31'b0};
            end
        end
    end

    // Padded so that any select value indexes in range; bit 0 is "no event".
    always_comb begin
        w_ev_pad                 = '0;
        w_ev_pad[NUM_EVENTS:1]   = bus.event_pulses;
    end

    always_comb begin
        w_inh_nxt = r_inh;
        if (bus.write_enable && w_is_inh) begin
            w_inh_nxt = bus.write_value[3 +: NUM_COUNTERS];
        end
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            logic w_hit, w_inc, w_wrap;
            w_hit        = bus.write_enable && (w_ci == 5'(i));
            w_inc        = w_ev_pad[r_sel[i]] && !r_inh[i];
            w_wrap       = 1'b0;
            w_cnt_nxt[i] = r_cnt[i];
            w_sel_nxt[i] = r_sel[i];
            w_of_nxt[i]  = r_of[i];
            // A software write to either half suppresses this cycle's increment.
            if (w_hit && w_is_lo) begin
                w_cnt_nxt[i][31:0] = bus.write_value;
            end else if (w_hit && w_is_hi) begin
                w_cnt_nxt[i][COUNTER_WIDTH-1:32] = bus.write_value[COUNTER_WIDTH-33:0];
            end else if (w_inc) begin
                w_cnt_nxt[i] = r_cnt[i] + COUNTER_WIDTH'(1);
                w_wrap       = &r_cnt[i];
            end
            if (w_hit && w_is_evh) begin
                w_of_nxt[i] = bus.write_value[31];
            end else if (w_wrap) begin
                w_of_nxt[i] = 1'b1;
            end
            if (w_hit && w_is_ev) begin
                w_sel_nxt[i] = (bus.write_value > 32'(NUM_EVENTS)) ? '0
                                                                  : bus.write_value[SELW-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_cnt[i] <= '0;
                r_sel[i] <= '0;
            end
            r_of    <= '0;
            r_inh   <= '0;
            r_lcofi <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                r_sel[i] <= w_sel_nxt[i];
            end
            r_of    <= w_of_nxt;
            r_inh   <= w_inh_nxt;
            r_lcofi <= |r_of;
        end
    end
endmodule
